// File: rtl/tilemap_layer_mixer.sv
// Two-layer tilemap mixer: latches per-tile attributes for layers A and B, aligns
// A's attribute with its delayed pixel path, and picks the visible pixel's CRAM address.
module tilemap_layer_mixer #(
    parameter int A_DELAY = 4
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_RST,
    input  logic        i_EMU_CLK6MPCEN_n,
    input  logic        i_ABS_n4H,
    input  logic        i_ABS_2H,
    input  logic [1:0]  i_A_MODE,
    input  logic [1:0]  i_B_MODE,
    input  logic [6:0]  i_A_PALETTE,
    input  logic [6:0]  i_B_PALETTE,
    input  logic        i_A_PRIO,
    input  logic        i_B_PRIO,
    input  logic [3:0]  i_A_PIXEL,
    input  logic [3:0]  i_B_PIXEL,
    input  logic        i_A_TRN_n,
    input  logic        i_B_TRN_n,
    output logic [11:0] o_CRAM_ADDR,
    output logic        o_OPAQUE
);

    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic       pix_en;
    logic       h2_dl;
    logic       px7;
    logic       px3;
    logic [7:0] a_fetch;
    logic [7:0] b_fetch;
    logic [7:0] a_active;
    logic [7:0] b_active;
    logic [7:0] a_dly [A_DELAY];
    logic [7:0] a_attr;
    logic [11:0] sel_addr;
    logic        sel_opaque;
    logic        unused_b_prio;

    assign pix_en = ~i_EMU_CLK6MPCEN_n;
    assign px7    = i_ABS_2H & h2_dl & ~i_ABS_n4H;
    assign px3    = i_ABS_2H & h2_dl &  i_ABS_n4H;
    assign a_attr = a_dly[A_DELAY-1];

    // B's priority bit travels with its attribute but never affects the selection.
    assign unused_b_prio = b_active[7];

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_addr   = 12'h000;
        sel_opaque = 1'b0;
        if (i_A_TRN_n && a_attr[7]) begin
            sel_addr   = {1'b0, a_attr[6:0], i_A_PIXEL};
            sel_opaque = 1'b1;
        end else if (i_B_TRN_n) begin
            sel_addr   = {1'b1, b_active[6:0], i_B_PIXEL};
            sel_opaque = 1'b1;
        end else if (i_A_TRN_n) begin
            sel_addr   = {1'b0, a_attr[6:0], i_A_PIXEL};
            sel_opaque = 1'b1;
        end
    end

    // NOTE: non-blocking assignments make a load that coincides with a strobe read
    // the fetch latch's old value, which is exactly the intended hardware behaviour.
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
        if (i_EMU_RST) begin
            h2_dl       <= 1'b0;
            a_fetch     <= 8'h00;
            b_fetch     <= 8'h00;
            a_active    <= 8'h00;
            b_active    <= 8'h00;
            o_CRAM_ADDR <= 12'h000;
            o_OPAQUE    <= 1'b0;
            // NOTE: the delay line is cleared too; stale attributes would otherwise
            // colour the first pixels after a mid-line reset.
            for (int i = 0; i < A_DELAY; i++) a_dly[i] <= 8'h00;
        end else if (pix_en) begin
            h2_dl <= i_ABS_2H;
            if (px7) a_fetch <= {i_A_PRIO, i_A_PALETTE};
            if (px3) b_fetch <= {i_B_PRIO, i_B_PALETTE};
            if (i_A_MODE == MODE_LOAD) a_active <= a_fetch;
            if (i_B_MODE == MODE_LOAD) b_active <= b_fetch;
            a_dly[0] <= a_active;
            for (int i = 1; i < A_DELAY; i++) a_dly[i] <= a_dly[i-1];
            o_CRAM_ADDR <= sel_addr;
            o_OPAQUE    <= sel_opaque;
        end
    end

endmodule
